// File: rtl/score_display.sv
// Score display: converts the 6-bit game score to BCD with a shift-and-add-3
// FSM and multiplexes it onto a 4-digit active-low seven-segment display.
// Optional high-score tracking is enabled by defining SCORE_HISCORE_EN.
module score_display #(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned BLINK_BITS   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] score,
  input  logic       colision,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ADD3  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam int unsigned SH_W = 14;

  logic [2:0]              state, state_next;
  logic                    pass_hi, pass_hi_next;
  logic [5:0]              score_last;
  logic [SH_W-1:0]         shreg;
  logic [SH_W-1:0]         shreg_add_c;
  logic [2:0]              cnt;
  logic [7:0]              cur_bcd;
  logic [REFRESH_BITS-1:0] refresh;
  logic [BLINK_BITS-1:0]   blink;
  logic                    hi_pending_c;
  logic [5:0]              load_hi_c;

`ifdef SCORE_HISCORE_EN
  logic [5:0] hi_bin, hi_last;
  logic [7:0] hi_bcd;
  logic       colision_q;

  assign hi_pending_c = (hi_bin != hi_last);
  assign load_hi_c    = hi_bin;

  // High-score capture on crash rising edge, plus bookkeeping for its BCD pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_bin     <= 6'd0;
      hi_last    <= 6'd0;
      hi_bcd     <= 8'd0;
      colision_q <= 1'b0;
    end else begin
      colision_q <= colision;
      if (colision && !colision_q && (score_last > hi_bin))
        hi_bin <= score_last;
      if (state == LOAD && pass_hi)
        hi_last <= hi_bin;
      if (state == DONE && pass_hi)
        hi_bcd <= shreg[13:6];
    end
  end
`else
  assign hi_pending_c = 1'b0;
  assign load_hi_c    = 6'd0;
`endif

  // Add-3 correction applied to both BCD nibbles
  always_comb begin
    shreg_add_c = shreg;
    if (shreg[13:10] >= 4'd5) shreg_add_c[13:10] = 4'(shreg[13:10] + 4'd3);
    if (shreg[9:6]   >= 4'd5) shreg_add_c[9:6]   = 4'(shreg[9:6] + 4'd3);
  end

  // Conversion FSM next-state; the high-score pass follows the current-score pass
  always_comb begin
    state_next   = state;
    pass_hi_next = pass_hi;
    case (state)
      IDLE: begin
        if (score != score_last) begin
          state_next   = LOAD;
          pass_hi_next = 1'b0;
        end else if (hi_pending_c) begin
          state_next   = LOAD;
          pass_hi_next = 1'b1;
        end
      end
      LOAD:  state_next = ADD3;
      ADD3:  state_next = SHIFT;
      SHIFT: state_next = (cnt == 3'd5) ? DONE : ADD3;
      DONE: begin
        if (!pass_hi && hi_pending_c) begin
          state_next   = LOAD;
          pass_hi_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pass_hi <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      pass_hi <= pass_hi_next;
      busy    <= (state_next != IDLE);
    end
  end

  // Double-dabble datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_last <= 6'd0;
      shreg      <= '0;
      cnt        <= 3'd0;
      cur_bcd    <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          cnt <= 3'd0;
          if (pass_hi) begin
            shreg <= {8'd0, load_hi_c};
          end else begin
            score_last <= score;
            shreg      <= {8'd0, score};
          end
        end
        ADD3:  shreg <= shreg_add_c;
        SHIFT: begin
          shreg <= {shreg[SH_W-2:0], 1'b0};
          cnt   <= 3'(cnt + 3'd1);
        end
        DONE:  if (!pass_hi) cur_bcd <= shreg[13:6];
        default: ;
      endcase
    end
  end

  // Free-running refresh and blink counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh <= '0;
      blink   <= '0;
    end else begin
      refresh <= REFRESH_BITS'(refresh + REFRESH_BITS'(1));
      blink   <= BLINK_BITS'(blink + BLINK_BITS'(1));
    end
  end

  logic [1:0] sel_c;
  logic       blink_off_c;
  logic [3:0] digit_c;
  logic       blank_c;
  logic [6:0] pat_c;

  assign sel_c       = refresh[REFRESH_BITS-1:REFRESH_BITS-2];
  assign blink_off_c = colision & ~blink[BLINK_BITS-1];

  // Digit selection with leading-zero and crash-blink blanking
  always_comb begin
    digit_c = 4'd0;
    blank_c = 1'b1;
    case (sel_c)
      2'd0: begin
        digit_c = cur_bcd[3:0];
        blank_c = blink_off_c;
      end
      2'd1: begin
        digit_c = cur_bcd[7:4];
        blank_c = blink_off_c | (cur_bcd[7:4] == 4'd0);
      end
`ifdef SCORE_HISCORE_EN
      2'd2: begin
        digit_c = hi_bcd[3:0];
        blank_c = 1'b0;
      end
      2'd3: begin
        digit_c = hi_bcd[7:4];
        blank_c = (hi_bcd[7:4] == 4'd0);
      end
`endif
      default: ;
    endcase
  end

  // Seven-segment decode, active-low g..a
  always_comb begin
    pat_c = 7'b1111111;
    case (digit_c)
      4'd0: pat_c = 7'b1000000;
      4'd1: pat_c = 7'b1111001;
      4'd2: pat_c = 7'b0100100;
      4'd3: pat_c = 7'b0110000;
      4'd4: pat_c = 7'b0011001;
      4'd5: pat_c = 7'b0010010;
      4'd6: pat_c = 7'b0000010;
      4'd7: pat_c = 7'b1111000;
      4'd8: pat_c = 7'b0000000;
      4'd9: pat_c = 7'b0010000;
      default: pat_c = 7'b1111111;
    endcase
  end

  // Registered anode and segment outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << sel_c);
      seg <= {1'b1, blank_c ? 7'b1111111 : pat_c};
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display against a latency/arithmetic
// reference model of the display contents.
module tb_score_display;

  localparam int unsigned RB = 4;
  localparam int unsigned BB = 6;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] score;
  logic       colision;
  logic [3:0] an;
  logic [7:0] seg;
  logic       busy;

  score_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .colision (colision),
    .an       (an),
    .seg      (seg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  localparam logic [6:0] SEG_TAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  // Reference model: a conversion is a 14-cycle job; the operand is sampled on its
  // 2nd edge and its decimal digits appear on its last edge.
  int m_phase, m_job_hi, m_operand, m_last, m_cur_t, m_cur_o;
  int m_hi, m_hi_last, m_hi_t, m_hi_o, m_colq, m_refresh, m_blink;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_busy;

  task automatic model_reset();
    m_phase = 0; m_job_hi = 0; m_operand = 0; m_last = 0; m_cur_t = 0; m_cur_o = 0;
    m_hi = 0; m_hi_last = 0; m_hi_t = 0; m_hi_o = 0; m_colq = 0;
    m_refresh = 0; m_blink = 0;
    exp_an = 4'hF; exp_seg = 8'hFF; exp_busy = 1'b0;
  endtask

  task automatic model_step();
    int sel, d, last_old, hi_old;
    bit boff, bl;
    sel  = (m_refresh >> (RB - 2)) & 3;
    boff = colision && (((m_blink >> (BB - 1)) & 1) == 0);
    case (sel)
      0: begin d = m_cur_o; bl = boff; end
      1: begin d = m_cur_t; bl = boff || (d == 0); end
      2: begin d = m_hi_o;  bl = !HI_EN; end
      default: begin d = m_hi_t; bl = !HI_EN || (d == 0); end
    endcase
    exp_an  = 4'(~(1 << sel));
    exp_seg = {1'b1, bl ? 7'b1111111 : SEG_TAB[d]};

    last_old = m_last;
    hi_old   = m_hi;
    if (m_phase == 0) begin
      if (int'(score) != m_last) begin m_phase = 1; m_job_hi = 0; end
      else if (HI_EN && m_hi != m_hi_last) begin m_phase = 1; m_job_hi = 1; end
    end else if (m_phase == 1) begin
      if (m_job_hi != 0) begin m_operand = m_hi; m_hi_last = m_hi; end
      else begin m_operand = int'(score); m_last = int'(score); end
      m_phase = 2;
    end else if (m_phase < 14) begin
      m_phase++;
    end else begin
      if (m_job_hi != 0) begin m_hi_t = m_operand / 10; m_hi_o = m_operand % 10; end
      else begin m_cur_t = m_operand / 10; m_cur_o = m_operand % 10; end
      if (m_job_hi == 0 && HI_EN && hi_old != m_hi_last) begin m_phase = 1; m_job_hi = 1; end
      else m_phase = 0;
    end
    exp_busy = (m_phase != 0);

    if (HI_EN && colision && m_colq == 0 && last_old > hi_old) m_hi = last_old;
    m_colq    = colision ? 1 : 0;
    m_refresh = (m_refresh + 1) % (1 << RB);
    m_blink   = (m_blink + 1) % (1 << BB);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Compare every registered output each cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic crash_pulse();
    colision = 1'b1;
    run(3);
    colision = 1'b0;
    run(3);
  endtask

  initial begin
    int k;
    reset = 1'b1; score = 6'd0; colision = 1'b0;
    run(2);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_busy", 32'(busy), 32'h0);
    chk_en = 1'b1;
    reset  = 1'b0;
    run(40);

    score = 6'd47; run(40);
    score = 6'd63; run(5);
    score = 6'd9;  run(60);

    score = 6'd12; run(30);
    colision = 1'b1; run(140);
    colision = 1'b0; run(10);

    score = 6'd30; run(30); crash_pulse();
    score = 6'd25; run(30); crash_pulse();
`ifdef SCORE_HISCORE_EN
    check("hi_after_25", 32'(dut.hi_bin), 32'd30);
`endif
    score = 6'd41; run(30); crash_pulse(); run(40);
`ifdef SCORE_HISCORE_EN
    check("hi_after_41", 32'(dut.hi_bin), 32'd41);
`endif

    score = 6'd50;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("busy_seen", 32'(k < 20), 32'd1);
    run(2);
    #2 reset = 1'b1;
    #1;
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    score = 6'd5;
    @(negedge clk);
    reset = 1'b0;
    run(40);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) score = 6'($urandom);
      if ($urandom_range(0, 39) == 0) colision = ~colision;
    end
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
